// File: rtl/composite_video_pkg.sv
// composite_video_pkg
// Shared types and timing constants for the composite video generator and
// decoder: FSM state, sync classification result, classifier event bundle,
// digitised level encodings and 27 MHz line/sync timing.
package composite_video_pkg;

  typedef enum logic [1:0] {SEARCH, SYNC_LOW, ACTIVE, BLANK} state_t;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_GLITCH, CLS_HSYNC, CLS_VSYNC, CLS_ERROR
  } sync_class_t;

  // Per-cycle view of the (optionally filtered) sync line.
  // cls is only meaningful in the cycle where rise is set.
  typedef struct packed {
    logic        low;
    logic        fall;
    logic        rise;
    sync_class_t cls;
  } sync_evt_t;

  localparam logic [1:0] LEVEL_SYNC  = 2'b00;
  localparam logic [1:0] LEVEL_BLACK = 2'b01;
  localparam logic [1:0] LEVEL_WHITE = 2'b10;

  localparam int HSYNC_CYCLES    = 127;
  localparam int VSYNC_CYCLES    = 1590;
  localparam int LINE_CYCLES     = 1716;
  localparam int LINES_PER_FRAME = 262;

  localparam int         WIDTH_BITS = 11;
  localparam logic [10:0] WIDTH_MAX = 11'h7FF;

  function automatic logic is_sync(input logic [1:0] lvl);
    return lvl == LEVEL_SYNC;
  endfunction

endpackage

// File: rtl/sync_pulse_classifier.sv
// sync_pulse_classifier
// Detects sync-low, its edges, counts the low width and classifies the pulse
// on its first high sample.
// Optional macro COMPOSITE_GLITCH_FILTER_EN: 3-tap majority filter on the
// sync detect, delaying every sync edge by 2 cycles (width preserved).
// Ports:
//   clk, reset_n  clock / async active-low reset
//   level_i [1:0] digitised video level
//   evt           sync level, fall/rise strobes and classification
module sync_pulse_classifier
  import composite_video_pkg::*;
#(
  parameter int HSYNC_MIN = 100,
  parameter int HSYNC_MAX = 200,
  parameter int VSYNC_MIN = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] level_i,
  output sync_evt_t  evt
);

  logic sync_low, low_q, fall, rise;
  logic [WIDTH_BITS-1:0] width;
  sync_class_t cls;

`ifdef COMPOSITE_GLITCH_FILTER_EN
  // Taps hold registered samples so both edges see the same 2-cycle delay.
  logic [2:0] taps;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) taps <= 3'b111;
    else          taps <= {taps[1:0], is_sync(level_i)};
  end
  assign sync_low = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
`else
  assign sync_low = is_sync(level_i);
`endif

  // low_q resets to "low" so a pulse already in progress at reset release
  // never produces a falling edge; only a fully observed pulse is classified.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      low_q <= 1'b1;
      width <= '0;
    end else begin
      low_q <= sync_low;
      if (sync_low)
        width <= !low_q ? 11'd1 : (width == WIDTH_MAX ? width : width + 11'd1);
    end
  end

  assign fall = sync_low & ~low_q;
  assign rise = ~sync_low & low_q;

  always_comb begin
    cls = CLS_NONE;
    if (rise) begin
      if (width < 11'(HSYNC_MIN))       cls = CLS_GLITCH;
      else if (width <= 11'(HSYNC_MAX)) cls = CLS_HSYNC;
      else if (width >= 11'(VSYNC_MIN)) cls = CLS_VSYNC;
      else                              cls = CLS_ERROR;
    end
  end

  assign evt = '{low: sync_low, fall: fall, rise: rise, cls: cls};

endmodule

// File: rtl/composite_sync_decoder.sv
// composite_sync_decoder
// Composite sync decoder: hsync/vsync pulses, line and pixel counters, pixel
// strobes and lock tracking. Optional macro COMPOSITE_GLITCH_FILTER_EN (see
// sync_pulse_classifier) adds a 2-cycle sync majority filter.
// Ports:
//   clk, reset_n       clock / async active-low reset
//   level_i [1:0]      digitised level (00 sync, 01 black, 1x white)
//   hsync_o, vsync_o   one-cycle sync pulses
//   locked_o           set after two consecutive vsyncs
//   line_o [8:0]       current line, 0..261
//   pixel_x_o [7:0]    index of the pixel being strobed
//   pixel_valid_o      pixel strobe, pixel_o [1:0] its sampled level
module composite_sync_decoder
  import composite_video_pkg::*;
#(
  parameter int HSYNC_MIN    = 100,
  parameter int HSYNC_MAX    = 200,
  parameter int VSYNC_MIN    = 1000,
  parameter int PIXEL_CYCLES = 7,
  parameter int PIXEL_COUNT  = 256,
  parameter int LINE_TIMEOUT = 3432
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] level_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       locked_o,
  output logic [8:0] line_o,
  output logic [7:0] pixel_x_o,
  output logic       pixel_valid_o,
  output logic [1:0] pixel_o
);

  sync_evt_t   evt;
  state_t      state, ret_state;
  logic        vsync_seen, timeout;
  logic [15:0] run, phase;
  logic [8:0]  pix_idx;

  sync_pulse_classifier #(
    .HSYNC_MIN(HSYNC_MIN), .HSYNC_MAX(HSYNC_MAX), .VSYNC_MIN(VSYNC_MIN)
  ) u_cls (
    .clk(clk), .reset_n(reset_n), .level_i(level_i), .evt(evt)
  );

  // run counts samples since the last sync edge, the edge sample being 1.
  assign timeout = !(evt.fall | evt.rise) && run == 16'(LINE_TIMEOUT - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SEARCH;
      ret_state     <= SEARCH;
      vsync_seen    <= 1'b0;
      run           <= '0;
      phase         <= '0;
      pix_idx       <= '0;
      hsync_o       <= 1'b0;
      vsync_o       <= 1'b0;
      locked_o      <= 1'b0;
      line_o        <= '0;
      pixel_x_o     <= '0;
      pixel_valid_o <= 1'b0;
      pixel_o       <= '0;
    end else begin
      hsync_o       <= 1'b0;
      vsync_o       <= 1'b0;
      pixel_valid_o <= 1'b0;

      if (evt.fall | evt.rise)          run <= 16'd1;
      else if (run != 16'(LINE_TIMEOUT)) run <= run + 16'd1;

      case (state)
        SEARCH: if (evt.fall) begin
          state     <= SYNC_LOW;
          ret_state <= SEARCH;
        end
        SYNC_LOW: if (evt.rise) begin
          case (evt.cls)
            CLS_GLITCH: state <= ret_state;
            CLS_HSYNC: begin
              hsync_o   <= 1'b1;
              line_o    <= (line_o == 9'(LINES_PER_FRAME - 1)) ? 9'd0 : line_o + 9'd1;
              pixel_x_o <= '0;
              pix_idx   <= '0;
              phase     <= '0;
              state     <= ACTIVE;
            end
            CLS_VSYNC: begin
              vsync_o    <= 1'b1;
              line_o     <= '0;
              locked_o   <= locked_o | vsync_seen;
              vsync_seen <= 1'b1;
              state      <= BLANK;
            end
            default: begin
              locked_o   <= 1'b0;
              vsync_seen <= 1'b0;
              state      <= SEARCH;
            end
          endcase
        end
        ACTIVE: begin
          // A sync abandons the line; a glitch then resumes in BLANK since
          // the pixel phase is lost.
          if (evt.low) begin
            state     <= SYNC_LOW;
            ret_state <= BLANK;
          end else if (phase == 16'(PIXEL_CYCLES - 1)) begin
            phase         <= '0;
            pixel_valid_o <= 1'b1;
            pixel_o       <= level_i;
            pixel_x_o     <= pix_idx[7:0];
            pix_idx       <= pix_idx + 9'd1;
            if (pix_idx == 9'(PIXEL_COUNT - 1)) state <= BLANK;
          end else begin
            phase <= phase + 16'd1;
          end
        end
        BLANK: if (evt.low) begin
          state     <= SYNC_LOW;
          ret_state <= BLANK;
        end
        default: state <= SEARCH;
      endcase

      if (timeout) begin
        locked_o   <= 1'b0;
        vsync_seen <= 1'b0;
        state      <= SEARCH;
      end
    end
  end

endmodule

// File: tb/tb_composite_sync_decoder.sv
// tb_composite_sync_decoder
// Table of sync pulses with expected class/line/lock/state, a scoreboard of
// expected sync pulses and pixel strobes (cycle, index, level), plus hand
// sequences for line wrap, reset mid-line, reset during a pulse, lock and
// timeout. Honours COMPOSITE_GLITCH_FILTER_EN (2-cycle sync latency).
module tb_composite_sync_decoder;
  import composite_video_pkg::*;

`ifdef COMPOSITE_GLITCH_FILTER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int PXC = 7;
  localparam int PXN = 256;
  localparam int TMO = 3432;

  typedef enum int {K_NONE, K_H, K_V} kind_t;
  typedef struct { int cyc; kind_t kind; int line; } sync_exp_t;
  typedef struct { int cyc; int x; int pix; } pix_exp_t;
  typedef struct { int w; int hold; kind_t kind; int line; bit locked; state_t st; } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] level = LEVEL_BLACK;
  logic       hsync_o, vsync_o, locked_o, pixel_valid_o;
  logic [8:0] line_o;
  logic [7:0] pixel_x_o;
  logic [1:0] pixel_o;

  composite_sync_decoder dut (
    .clk(clk), .reset_n(reset_n), .level_i(level),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .locked_o(locked_o),
    .line_o(line_o), .pixel_x_o(pixel_x_o),
    .pixel_valid_o(pixel_valid_o), .pixel_o(pixel_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  sync_exp_t sync_q[$];
  pix_exp_t  pix_q[$];

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  function automatic logic [1:0] pat(input int n);
    case (n % 3)
      0:       return 2'b01;
      1:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Scoreboard side: every pulse/strobe must match the head of its queue.
  always @(negedge clk) begin
    sync_exp_t se;
    pix_exp_t  pe;
    if (reset_n === 1'b1) begin
      if (hsync_o || vsync_o || pixel_valid_o)
        chk("pulse_exclusive", $countones({hsync_o, vsync_o, pixel_valid_o}), 1);
      if (hsync_o || vsync_o) begin
        if (sync_q.size() == 0) chk("sync_unexpected", cyc, -1);
        else begin
          se = sync_q.pop_front();
          chk("sync_cycle", cyc, se.cyc);
          chk("sync_kind", hsync_o ? int'(K_H) : int'(K_V), int'(se.kind));
          chk("sync_line", int'(line_o), se.line);
        end
      end
      if (pixel_valid_o) begin
        if (pix_q.size() == 0) chk("pixel_unexpected", cyc, -1);
        else begin
          pe = pix_q.pop_front();
          chk("pixel_cycle", cyc, pe.cyc);
          chk("pixel_x", int'(pixel_x_o), pe.x);
          chk("pixel_level", int'(pixel_o), pe.pix);
        end
      end
    end
  end

  task automatic step(input logic [1:0] lvl);
    level = lvl;
    @(posedge clk);
    #1;
  endtask

  // w low samples, then black; e0 = edge at which the decoder sees the rise.
  task automatic pulse(input int w, input kind_t k, input int ln, output int e0);
    for (int i = 0; i < w; i++) begin
      step(LEVEL_SYNC);
      if (i == w - 1 && w >= 3) chk("state_in_low", int'(dut.state), int'(SYNC_LOW));
    end
    if (k != K_NONE) sync_q.push_back('{cyc + 1 + LAT, k, ln});
    step(LEVEL_BLACK);
    for (int i = 0; i < LAT; i++) step(LEVEL_BLACK);
    e0 = cyc;
  endtask

  task automatic hold(input int n, input bit active, input int e0);
    for (int j = 0; j < n; j++) begin
      int ed;
      int d;
      logic [1:0] lv;
      ed = cyc + 1;
      d  = ed - e0;
      lv = pat(ed);
      if (active && d % PXC == 0 && d / PXC >= 1 && d / PXC <= PXN)
        pix_q.push_back('{ed, d / PXC - 1, int'(lv)});
      step(lv);
    end
  endtask

  function automatic int outs();
    return int'({hsync_o, vsync_o, locked_o, line_o, pixel_x_o, pixel_valid_o, pixel_o});
  endfunction

  vec_t vecs[16];

  initial begin
    int e0;
    vecs = '{
      '{1590, 300,  K_V,    0, 1'b0, BLANK},
      '{127,  1800, K_H,    1, 1'b0, ACTIVE},
      '{127,  100,  K_H,    2, 1'b0, ACTIVE},
      '{40,   200,  K_NONE, 2, 1'b0, BLANK},
      '{1590, 200,  K_V,    0, 1'b1, BLANK},
      '{127,  1800, K_H,    1, 1'b1, ACTIVE},
      '{1590, 18,   K_V,    0, 1'b1, BLANK},
      '{500,  18,   K_NONE, 0, 1'b0, SEARCH},
      '{150,  1800, K_H,    1, 1'b0, ACTIVE},
      '{100,  18,   K_H,    2, 1'b0, ACTIVE},
      '{99,   18,   K_NONE, 2, 1'b0, BLANK},
      '{200,  18,   K_H,    3, 1'b0, ACTIVE},
      '{201,  18,   K_NONE, 3, 1'b0, SEARCH},
      '{999,  18,   K_NONE, 3, 1'b0, SEARCH},
      '{1000, 18,   K_V,    0, 1'b0, BLANK},
      '{1000, 18,   K_V,    0, 1'b1, BLANK}
    };

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_outputs", outs(), 0);
    chk("reset_state", int'(dut.state), int'(SEARCH));
    repeat (3) step(LEVEL_BLACK);
    reset_n = 1'b1;
    hold(10, 1'b0, 0);
    chk("idle_outputs", outs(), 0);

    foreach (vecs[i]) begin
      pulse(vecs[i].w, vecs[i].kind, vecs[i].line, e0);
      chk("vec_state", int'(dut.state), int'(vecs[i].st));
      chk("vec_locked", int'(locked_o), int'(vecs[i].locked));
      chk("vec_line", int'(line_o), vecs[i].line);
      hold(vecs[i].hold, vecs[i].kind == K_H, e0);
      if (vecs[i].kind == K_H && vecs[i].hold >= 1800) begin
        chk("line_end_state", int'(dut.state), int'(BLANK));
        chk("line_end_x", int'(pixel_x_o), PXN - 1);
      end
    end

    // 262 short lines: line counter wraps 261 -> 0.
    for (int i = 1; i <= LINES_PER_FRAME; i++) begin
      pulse(100, K_H, i % LINES_PER_FRAME, e0);
      hold(3, 1'b1, e0);
    end
    chk("wrap_line", int'(line_o), 0);
    chk("wrap_locked", int'(locked_o), 1);

    // Reset in the middle of an active line.
    pulse(127, K_H, 1, e0);
    hold(30, 1'b1, e0);
    chk("midline_x", int'(pixel_x_o), 3);
    chk("midline_locked", int'(locked_o), 1);
    reset_n = 1'b0;
    #1;
    chk("midline_reset_outputs", outs(), 0);
    chk("midline_reset_state", int'(dut.state), int'(SEARCH));

    // Released mid-pulse: that partial pulse must not be classified.
    repeat (3) step(LEVEL_SYNC);
    reset_n = 1'b1;
    repeat (127) step(LEVEL_SYNC);
    step(LEVEL_BLACK);
    hold(20, 1'b0, 0);
    chk("partial_pulse_state", int'(dut.state), int'(SEARCH));
    chk("partial_pulse_line", int'(line_o), 0);

    pulse(127, K_H, 1, e0);
    chk("first_hsync_state", int'(dut.state), int'(ACTIVE));
    hold(18, 1'b1, e0);

    pulse(1590, K_V, 0, e0);
    chk("vsync1_locked", int'(locked_o), 0);
    hold(18, 1'b0, e0);
`ifdef COMPOSITE_GLITCH_FILTER_EN
    step(LEVEL_SYNC);
    for (int i = 0; i < 4; i++) begin
      step(LEVEL_BLACK);
      chk("spike_state", int'(dut.state), int'(BLANK));
    end
`endif
    pulse(1590, K_V, 0, e0);
    chk("vsync2_locked", int'(locked_o), 1);

    // Timeout: 3432 samples of black including the rise sample.
    repeat (TMO - 2) step(LEVEL_BLACK);
    chk("timeout_before", int'(locked_o), 1);
    step(LEVEL_BLACK);
    chk("timeout_locked", int'(locked_o), 0);
    chk("timeout_state", int'(dut.state), int'(SEARCH));

    repeat (5) step(LEVEL_BLACK);
    chk("sync_queue_drained", sync_q.size(), 0);
    chk("pixel_queue_drained", pix_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
